serdes_deframer: RTL and testbench

SERDES_DEFRAMER -- requirements
Module: serdes_deframer

---
 rtl/serdes_deframer.sv | 164 ++++++++++++++++
 tb/tb_serdes_deframer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serdes_deframer.sv
// Byte-stream deframer: hunts for SYNC_BYTE/payload pairs, verifies and locks alignment, and buffers payload in a FIFO.
// Optional feature: define DEFRAMER_ERRCNT_EN to build the saturating sync-error counter on err_cnt.
module serdes_deframer #(
    parameter logic [7:0] SYNC_BYTE  = 8'h81,
    parameter int         LOCK_CNT   = 3,
    parameter int         LOSS_CNT   = 2,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  para_in,
    input  logic        byte_stb,
    output logic [7:0]  dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        locked,
    output logic        overflow,
    output logic [15:0] err_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(LOSS_CNT + 1);
    localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_CNT - 1);
    localparam logic [MW-1:0] MISS_LAST = MW'(LOSS_CNT - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t        r_state;
    logic          r_phase;
    logic [GW-1:0] r_good_cnt;
    logic [MW-1:0] r_miss_cnt;
    logic          r_locked;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic w_marker;
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_push_ok;

    assign w_marker  = (para_in == SYNC_BYTE);
    assign w_push    = reset && byte_stb && (r_state == LOCKED) && r_phase;
    assign w_full    = (r_count == FULL_CNT);
    assign w_pop     = dout_valid && dout_ready;
    assign w_push_ok = w_push && (!w_full || w_pop);

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= HUNT;
            r_phase    <= 1'b0;
            r_good_cnt <= '0;
            r_miss_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (byte_stb) begin
            case (r_state)
                HUNT: begin
                    if (w_marker) begin
                        r_phase    <= 1'b1;
                        r_good_cnt <= GW'(1);
                        if (LOCK_CNT <= 1) begin
                            r_state    <= LOCKED;
                            r_locked   <= 1'b1;
                            r_good_cnt <= '0;
                        end else begin
                            r_state <= VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    if (r_phase) begin
                        r_phase <= 1'b0;
                    end else if (w_marker) begin
                        r_phase <= 1'b1;
                        if (r_good_cnt == LOCK_LAST) begin
                            r_state    <= LOCKED;
                            r_locked   <= 1'b1;
                            r_good_cnt <= '0;
                        end else begin
                            r_good_cnt <= r_good_cnt + GW'(1);
                        end
                    end else begin
                        // The failing byte is consumed here, not re-tried as a marker.
                        r_state    <= HUNT;
                        r_good_cnt <= '0;
                    end
                end
                LOCKED: begin
                    r_phase <= ~r_phase;
                    if (!r_phase) begin
                        if (w_marker) begin
                            r_miss_cnt <= '0;
                        end else if (r_miss_cnt == MISS_LAST) begin
                            r_state    <= HUNT;
                            r_locked   <= 1'b0;
                            r_miss_cnt <= '0;
                            r_phase    <= 1'b0;
                        end else begin
                            r_miss_cnt <= r_miss_cnt + MW'(1);
                        end
                    end
                end
                default: r_state <= HUNT;
            endcase
        end
    end

    // NOTE: the payload storage is deliberately not reset; the empty count masks whatever it holds.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= para_in;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout_valid = (r_count != '0);
    assign dout       = dout_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign locked     = r_locked;
    assign overflow   = r_overflow;

`ifdef DEFRAMER_ERRCNT_EN
    logic        w_sync_err;
    logic [15:0] r_err_cnt;

    assign w_sync_err = byte_stb && !r_phase && !w_marker &&
                        ((r_state == VERIFY) || (r_state == LOCKED));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err_cnt <= '0;
        end else if (w_sync_err && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_serdes_deframer.sv
// Self-checking bench for serdes_deframer: directed scenarios plus a randomized framed stream
// checked against a queue-based behavioural model of the framing rules.
module tb_serdes_deframer;

    localparam logic [7:0] SYNC     = 8'h81;
    localparam int         LOCK_CNT = 3;
    localparam int         LOSS_CNT = 2;
    localparam int         DEPTH    = 4;
`ifdef DEFRAMER_ERRCNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [7:0]  para_in;
    logic        byte_stb;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        locked;
    logic        overflow;
    logic [15:0] err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: alignment confidence, lock flag, payload queue.
    bit         m_locked;
    bit         m_want_payload;
    int         m_good;
    int         m_miss;
    bit         m_ovf;
    int         m_err;
    logic [7:0] m_q[$];

    serdes_deframer #(
        .SYNC_BYTE (SYNC),
        .LOCK_CNT  (LOCK_CNT),
        .LOSS_CNT  (LOSS_CNT),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .para_in   (para_in),
        .byte_stb  (byte_stb),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .locked    (locked),
        .overflow  (overflow),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] exp_err();
        if (!ERR_EN) return 16'h0000;
        return (m_err > 65535) ? 16'hFFFF : 16'(m_err);
    endfunction

    task automatic model_reset();
        m_locked       = 1'b0;
        m_want_payload = 1'b0;
        m_good         = 0;
        m_miss         = 0;
        m_ovf          = 1'b0;
        m_err          = 0;
        m_q.delete();
    endtask

    task automatic model_step(input logic stb, input logic [7:0] b, input logic rdy);
        int size_before = m_q.size();
        bit pop         = (size_before > 0) && rdy;
        bit push        = 1'b0;
        bit is_sync     = (b == SYNC);
        if (stb) begin
            if (m_locked) begin
                if (m_want_payload) begin
                    push = 1'b1;
                end else if (is_sync) begin
                    m_miss = 0;
                end else begin
                    m_miss++;
                    m_err++;
                    if (m_miss == LOSS_CNT) begin
                        m_locked = 1'b0;
                        m_miss   = 0;
                        m_good   = 0;
                    end
                end
                m_want_payload = !m_want_payload;
            end else if (m_good == 0) begin
                if (is_sync) begin
                    m_good         = 1;
                    m_want_payload = 1'b1;
                end
            end else if (m_want_payload) begin
                m_want_payload = 1'b0;
            end else if (is_sync) begin
                m_good++;
                m_want_payload = 1'b1;
                if (m_good >= LOCK_CNT) begin
                    m_locked = 1'b1;
                    m_good   = 0;
                end
            end else begin
                m_good = 0;
                m_err++;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (size_before == DEPTH && !pop) m_ovf = 1'b1;
            else m_q.push_back(b);
        end
    endtask

    // One clock: drive on the falling edge, update the model at the rising edge, settle 1 time unit.
    task automatic step(input logic stb, input logic [7:0] b, input logic rdy);
        @(negedge clk);
        byte_stb   = stb;
        para_in    = b;
        dout_ready = rdy;
        @(posedge clk);
        if (!reset) model_reset();
        else model_step(stb, b, rdy);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic rdy);
        step(1'b1, b, rdy);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        for (int i = 0; i < cycles; i++) step(1'($urandom), 8'($urandom), 1'($urandom));
        reset = 1'b1;
    endtask

    task automatic acquire_lock();
        send(SYNC, 1'b0);
        send(8'hA5, 1'b0);
        send(SYNC, 1'b0);
        send(8'h3C, 1'b0);
        send(SYNC, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'($urandom), 8'($urandom), 1'($urandom));
            n_tests++;
            if ({dout, dout_valid, locked, overflow, err_cnt} !== 27'd0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got dout=%h valid=%b locked=%b ovf=%b err=%h, want all zero",
                         i, dout, dout_valid, locked, overflow, err_cnt);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_lock_acquisition();
        logic [7:0] seq [8] = '{8'h81, 8'hA5, 8'h81, 8'h3C, 8'h81, 8'h7E, 8'h81, 8'h11};
        logic [7:0] want [2] = '{8'h7E, 8'h11};
        do_reset(5);
        for (int i = 0; i < 8; i++) begin
            send(seq[i], 1'b0);
            n_tests++;
            if (locked !== (i >= 4)) begin
                n_fail++;
                $display("FAIL lock_acq_locked[%0d]: got %b want %b", i, locked, (i >= 4));
            end
            n_tests++;
            if (dout_valid !== (i >= 5)) begin
                n_fail++;
                $display("FAIL lock_acq_valid[%0d]: got %b want %b", i, dout_valid, (i >= 5));
            end
        end
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (dout_valid !== 1'b1 || dout !== want[k]) begin
                n_fail++;
                $display("FAIL lock_acq_dout[%0d]: got valid=%b dout=%h want valid=1 dout=%h",
                         k, dout_valid, dout, want[k]);
            end
            step(1'b0, 8'h00, 1'b1);
        end
        n_tests++;
        if (dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_acq_drained: got valid=%b want 0", dout_valid);
        end
    endtask

    task automatic test_false_marker();
        do_reset(2);
        send(8'h81, 1'b0);
        send(8'h22, 1'b0);
        send(8'h55, 1'b0);
        n_tests++;
        if (err_cnt !== (ERR_EN ? 16'd1 : 16'd0)) begin
            n_fail++;
            $display("FAIL false_marker_err: got %0d want %0d", err_cnt, ERR_EN ? 1 : 0);
        end
        send(8'h81, 1'b0);
        n_tests++;
        if (locked !== 1'b0 || dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL false_marker_state: got locked=%b valid=%b want 0 0", locked, dout_valid);
        end
    endtask

    task automatic test_loss_of_lock();
        do_reset(2);
        acquire_lock();
        send(8'h7E, 1'b0);
        send(8'h00, 1'b0);
        n_tests++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL loss_first_miss: got locked=%b want 1", locked);
        end
        send(8'hAA, 1'b0);
        send(8'h00, 1'b0);
        n_tests++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL loss_second_miss: got locked=%b want 0", locked);
        end
        n_tests++;
        if (err_cnt !== (ERR_EN ? 16'd2 : 16'd0)) begin
            n_fail++;
            $display("FAIL loss_err: got %0d want %0d", err_cnt, ERR_EN ? 2 : 0);
        end
        n_tests++;
        if (dout_valid !== 1'b1 || dout !== 8'h7E) begin
            n_fail++;
            $display("FAIL loss_retain0: got valid=%b dout=%h want 1 7e", dout_valid, dout);
        end
        step(1'b0, 8'h00, 1'b1);
        n_tests++;
        if (dout_valid !== 1'b1 || dout !== 8'hAA) begin
            n_fail++;
            $display("FAIL loss_retain1: got valid=%b dout=%h want 1 aa", dout_valid, dout);
        end
        step(1'b0, 8'h00, 1'b1);
        n_tests++;
        if (dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL loss_drained: got valid=%b want 0", dout_valid);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] pl [5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        do_reset(2);
        acquire_lock();
        for (int k = 0; k < 5; k++) begin
            send(pl[k], 1'b0);
            n_tests++;
            if (overflow !== (k == 4)) begin
                n_fail++;
                $display("FAIL overflow_flag[%0d]: got %b want %b", k, overflow, (k == 4));
            end
            if (k < 4) send(SYNC, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (dout_valid !== 1'b1 || dout !== pl[k]) begin
                n_fail++;
                $display("FAIL overflow_drain[%0d]: got valid=%b dout=%h want 1 %h", k, dout_valid, dout, pl[k]);
            end
            step(1'b0, 8'h00, 1'b1);
        end
        n_tests++;
        if (dout_valid !== 1'b0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: got valid=%b ovf=%b want 0 1", dout_valid, overflow);
        end
        do_reset(1);
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_reset: got %b want 0", overflow);
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] pl [5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        do_reset(2);
        acquire_lock();
        for (int k = 0; k < 4; k++) begin
            send(pl[k], 1'b0);
            send(SYNC, 1'b0);
        end
        send(pl[4], 1'b1);
        n_tests++;
        if (overflow !== 1'b0 || dout_valid !== 1'b1 || dout !== 8'hA2) begin
            n_fail++;
            $display("FAIL full_pop_push: got ovf=%b valid=%b dout=%h want 0 1 a2", overflow, dout_valid, dout);
        end
        for (int k = 1; k < 5; k++) begin
            n_tests++;
            if (dout_valid !== 1'b1 || dout !== pl[k]) begin
                n_fail++;
                $display("FAIL full_pop_order[%0d]: got valid=%b dout=%h want 1 %h", k, dout_valid, dout, pl[k]);
            end
            step(1'b0, 8'h00, 1'b1);
        end
        n_tests++;
        if (dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pop_drained: got valid=%b want 0", dout_valid);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset(2);
        send(8'h81, 1'b0);
        send(8'h22, 1'b0);
        send(8'h55, 1'b0);
        acquire_lock();
        send(8'hB1, 1'b0);
        send(SYNC, 1'b0);
        send(8'hB2, 1'b0);
        send(SYNC, 1'b0);
        send(8'hB3, 1'b0);
        n_tests++;
        if (locked !== 1'b1 || dout_valid !== 1'b1 || err_cnt !== (ERR_EN ? 16'd1 : 16'd0)) begin
            n_fail++;
            $display("FAIL midstream_pre: got locked=%b valid=%b err=%0d want 1 1 %0d",
                     locked, dout_valid, err_cnt, ERR_EN ? 1 : 0);
        end
        reset = 1'b0;
        step(1'b1, SYNC, 1'b1);
        reset = 1'b1;
        n_tests++;
        if (dout_valid !== 1'b0 || locked !== 1'b0 || err_cnt !== 16'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL midstream_reset: got valid=%b locked=%b err=%0d ovf=%b want 0 0 0 0",
                     dout_valid, locked, err_cnt, overflow);
        end
        step(1'b0, 8'h00, 1'b1);
        n_tests++;
        if (dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midstream_after: got valid=%b want 0", dout_valid);
        end
    endtask

    task automatic test_random();
        bit         src_phase = 1'b0;
        int         rdy_pct   = 50;
        int         errs      = 0;
        logic       stb;
        logic       rdy;
        logic [7:0] b;
        do_reset(2);
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) rdy_pct = $urandom_range(5, 95);
            stb = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 99) < rdy_pct);
            b   = 8'($urandom);
            if (stb) begin
                if (!src_phase && $urandom_range(0, 99) < 92) b = SYNC;
                if ($urandom_range(0, 49) != 0) src_phase = !src_phase;
            end
            step(stb, b, rdy);
            n_tests++;
            if (dout_valid !== (m_q.size() != 0) || locked !== m_locked || overflow !== m_ovf ||
                err_cnt !== exp_err() || (m_q.size() != 0 && dout !== m_q[0])) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d]: got valid=%b dout=%h locked=%b ovf=%b err=%0d want valid=%b dout=%h locked=%b ovf=%b err=%0d",
                             c, dout_valid, dout, locked, overflow, err_cnt, (m_q.size() != 0),
                             (m_q.size() != 0) ? m_q[0] : 8'h00, m_locked, m_ovf, exp_err());
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        byte_stb   = 1'b0;
        para_in    = 8'h00;
        dout_ready = 1'b0;
        model_reset();
        test_reset();
        test_lock_acquisition();
        test_false_marker();
        test_loss_of_lock();
        test_overflow();
        test_full_pop();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
